// File: rtl/switch_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | switch_debounce: two-flop synchronizer and per-bit debouncer for the slide  |
// | switches, with registered rise/fall/any event pulses.   Rev 1.0             |
// +-----------------------------------------------------------------------------+
module switch_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any
);

  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      sw_any  <= 1'b0;
    end else begin
      r_s1    <= sw_raw;
      r_s2    <= r_s1;
      // An accepting bit always differs from its debounced level, so XOR takes the new value.
      sw_db   <= sw_db ^ w_accept;
      sw_rise <= w_accept & r_s2;
      sw_fall <= w_accept & ~r_s2;
      sw_any  <= |w_accept;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             w_mismatch;

      assign w_mismatch  = r_s2[i] ^ sw_db[i];
      assign w_accept[i] = w_mismatch && (r_cnt == C_TERMINAL);

      // Any return to the accepted level restarts the count; accepting also clears it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (!w_mismatch || w_accept[i]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + C_ONE;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/switch_debounce.md
# switch_debounce

Synchronizer and debouncer for the board slide switches, directly upstream of the switches PIO input port. It takes the raw, asynchronous, bouncing switch levels and makes each bit two-flop synchronized and individually debounced. It presents a stable bus that drives the PIO `in_port[9:0]`, plus per-bit rise/fall event pulses for optional interrupt or edge-capture logic.

## Interface
Parameters:
- `WIDTH`, default 10: number of switch bits; must equal the width of the PIO `in_port`.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable clk cycles needed to accept a new level (10 ms at 50 MHz); legal range 2 to 2^CNT_W−1.
- `CNT_W`, default 20: width of each per-bit counter.

Ports:
- `clk`, in, 1: system clock (Avalon slave clock of the PIO).
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `sw_raw`, in, WIDTH: raw switch pins; asynchronous to clk.
- `sw_db`, out, WIDTH: debounced level; connects to the PIO `in_port`.
- `sw_rise`, out, WIDTH: one-cycle pulse per bit when `sw_db` bit goes 0→1.
- `sw_fall`, out, WIDTH: one-cycle pulse per bit when `sw_db` bit goes 1→0.
- `sw_any`, out, 1: one-cycle pulse, equal to OR-reduce of (`sw_rise | sw_fall`).

## Operation
- Per bit i, the channels are fully independent. There is no shared counter.
- Synchronizer: `s1[i] <= sw_raw[i]`, then `s2[i] <= s1[i]`. Only `s2` is used downstream.
- Mismatch is `d[i] = s2[i] ^ sw_db[i]`.
- Counter `cnt[i]` (CNT_W bits) updates each cycle as follows:
  - if `d[i]`=0: `cnt[i] <= 0`.
  - if `d[i]`=1 and `cnt[i]` < DEBOUNCE_CYCLES−1: `cnt[i] <= cnt[i]+1`.
  - if `d[i]`=1 and `cnt[i]` == DEBOUNCE_CYCLES−1: `sw_db[i] <= s2[i]`, `cnt[i] <= 0`, and the matching `sw_rise[i]`/`sw_fall[i]` is asserted for that one cycle.
- The counter never wraps. The terminal compare is `==`, and a saturating counter is not needed because the accept always clears it.
- Any return of `s2` to `sw_db` before the terminal count restarts the count from 0. This is how bounce is rejected.
- Pulse outputs are registered and low in every cycle without an accept.
- `sw_any` is registered in the same cycle as the pulses; it is not derived combinationally from them one cycle later.
- Multiple bits may accept in the same cycle. Each asserts its own pulse, and `sw_any` asserts once.

## Timing
- Reset values: `s1`, `s2`, `cnt`, `sw_db`, `sw_rise`, `sw_fall`, and `sw_any` are all 0.
- A switch held high through reset appears on `sw_db` after DEBOUNCE_CYCLES+2 cycles following reset release, with a `sw_rise` pulse.
- Latency: `sw_raw[i]` changes and stays constant before clk edge E0.
  - `s2[i]` reflects the change after edge E0+1.
  - `sw_db[i]` and the pulse update at edge E0+1+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 edges counting E0.
- Glitch rejection: a `s2` excursion lasting at most DEBOUNCE_CYCLES−1 cycles never changes `sw_db`.
- Reset mid-count: all state clears immediately and asynchronously. Counting restarts from 0 after release.
- The PIO samples `sw_db` on its own registered read. `sw_db` is glitch-free because it is a flop output.

## Test plan
Benches run with `DEBOUNCE_CYCLES`=4, `WIDTH`=10, and `sw_raw` driven away from clk edges.
- Reset check: assert `reset_n`=0 mid-simulation with `sw_raw`=10'h3FF → all outputs are 0 immediately. Release → `sw_db`=10'h3FF and `sw_rise`=10'h3FF for exactly 1 cycle at edge 6 after release, and `sw_any`=1 for 1 cycle.
- Clean step: bit 3 goes 0→1 before edge E0 → `sw_db`=10'h008 at edge E0+5 (not E0+4). `sw_rise`=10'h008 for one cycle, and `sw_fall`=0 throughout.
- Bounce: bit 0 toggles 1,0,1,0 at 2-cycle intervals, then holds 1 → no `sw_db` change during the toggling. The accept occurs 6 edges after the last toggle, and there is exactly one `sw_rise` pulse.
- Short glitch: bit 9 is high for 3 cycles (s2-visible), then low → `sw_db` stays 0 and no pulses occur.
- Simultaneous events: bits 1 and 2 rise and bit 5 falls (from 1) at the same edge → `sw_rise`=10'h006 and `sw_fall`=10'h020 in the same cycle, with a single `sw_any` pulse.
- Reset mid-count: bit 4 rises, then `reset_n` is pulsed low 2 cycles later → no pulse is ever produced from the aborted count. After release, `sw_db[4]` sets 6 edges later.
